// File: rtl/fir_gen.sv
// fir_gen: AXI-Lite programmed, AXI-Stream FIR filter with internal tap and
// sample registers and a single shared multiply-accumulate unit.
module fir_gen #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_MAX    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rvalid,
  input  logic                   rready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic                   ss_tlast,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic                   sm_tlast
);
  localparam int W  = pDATA_WIDTH;
  localparam int IW = $clog2(pTAP_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_OUT, S_DONE} state_t;
  state_t state, state_nxt;

  logic signed [W-1:0] coef [pTAP_MAX];
  logic signed [W-1:0] x    [pTAP_MAX];
  logic        [W-1:0] data_length, tap_count, cnt, rd_val;
  logic signed [W-1:0] acc, acc_nxt;
  logic       [IW-1:0] tc, wptr, ridx, k;
  logic                wr_ack, wr_fire, start_req, ap_idle, ap_done, tlast_lat, last_out;

  function automatic logic is_coef(input logic [pADDR_WIDTH-1:0] a);
    return (a >= pADDR_WIDTH'('h40)) && (a < pADDR_WIDTH'('h40 + 4 * pTAP_MAX)) &&
           (a[1:0] == 2'b00);
  endfunction

  function automatic logic [IW-1:0] coef_sel(input logic [pADDR_WIDTH-1:0] a);
    logic [pADDR_WIDTH-1:0] off;
    off = a - pADDR_WIDTH'('h40);
    return off[IW+1:2];
  endfunction

  // Product truncated to W bits, accumulation wraps modulo 2^W.
  function automatic logic signed [W-1:0] mac_wrap(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] c,
                                                   input logic signed [W-1:0] s);
    logic signed [W-1:0] prod;
    prod = c * s;
    return a + prod;
  endfunction

  // A tap count of zero or above the register file size behaves as the full size.
  assign tc        = (tap_count == '0 || tap_count > W'(pTAP_MAX)) ? IW'(pTAP_MAX)
                                                                    : tap_count[IW-1:0];
  assign awready   = wr_ack;
  assign wready    = wr_ack;
  assign wr_fire   = wr_ack && awvalid && wvalid;
  assign start_req = wr_fire && (awaddr == '0) && wdata[0] && (state == S_IDLE);
  assign ap_idle   = (state == S_IDLE) || (state == S_DONE);
  assign last_out  = ((data_length != '0) && (cnt + W'(1) == data_length)) || tlast_lat;
  assign acc_nxt   = mac_wrap(acc, coef[k], x[ridx]);

  // State register.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) state <= S_IDLE;
    else             state <= state_nxt;
  end

  // Next-state and stream handshake outputs.
  always_comb begin
    state_nxt = state;
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    sm_tlast  = 1'b0;
    case (state)
      S_IDLE:    if (start_req) state_nxt = S_CLEAR;
      S_CLEAR:   state_nxt = S_WAIT_IN;
      S_WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) state_nxt = S_MAC;
      end
      S_MAC:     if (k == tc - IW'(1)) state_nxt = S_OUT;
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tlast  = last_out;
        if (sm_tready) state_nxt = last_out ? S_DONE : S_WAIT_IN;
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Register writes: one-cycle joint ready pulse, configuration locked while busy.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      wr_ack      <= 1'b0;
      data_length <= '0;
      tap_count   <= '0;
      for (int i = 0; i < pTAP_MAX; i++) coef[i] <= '0;
    end else begin
      wr_ack <= awvalid && wvalid && !wr_ack;
      if (wr_fire && ap_idle) begin
        if (awaddr == pADDR_WIDTH'('h10))      data_length <= wdata;
        else if (awaddr == pADDR_WIDTH'('h14)) tap_count   <= wdata;
        else if (is_coef(awaddr))              coef[coef_sel(awaddr)] <= wdata;
      end
    end
  end

  // Read data selection.
  always_comb begin
    rd_val = '0;
    if (araddr == '0) begin
      rd_val[1] = ap_done || (state == S_DONE);
      rd_val[2] = ap_idle;
    end else if (araddr == pADDR_WIDTH'('h10)) rd_val = data_length;
    else if (araddr == pADDR_WIDTH'('h14))     rd_val = W'(tc);
    else if (is_coef(araddr))                  rd_val = coef[coef_sel(araddr)];
  end

  // Read channel and sticky done flag, which clears once ap_ctrl is read.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      ap_done <= 1'b0;
    end else begin
      arready <= arvalid && !arready && !rvalid;
      if (arready && arvalid) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
      if (state == S_DONE)                             ap_done <= 1'b1;
      else if (arready && arvalid && araddr == '0)     ap_done <= 1'b0;
    end
  end

  // Sample buffer, MAC sequencing and output sample/count registers.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < pTAP_MAX; i++) x[i] <= '0;
      wptr      <= '0;
      ridx      <= '0;
      k         <= '0;
      cnt       <= '0;
      acc       <= '0;
      tlast_lat <= 1'b0;
      sm_tdata  <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          for (int i = 0; i < pTAP_MAX; i++) x[i] <= '0;
          wptr      <= '0;
          cnt       <= '0;
          tlast_lat <= 1'b0;
        end
        S_WAIT_IN: if (ss_tvalid) begin
          x[wptr]   <= ss_tdata;
          ridx      <= wptr;
          wptr      <= (wptr == tc - IW'(1)) ? '0 : wptr + IW'(1);
          tlast_lat <= ss_tlast;
          k         <= '0;
          acc       <= '0;
        end
        S_MAC: begin
          acc  <= acc_nxt;
          k    <= k + IW'(1);
          ridx <= (ridx == '0) ? tc - IW'(1) : ridx - IW'(1);
          if (k == tc - IW'(1)) sm_tdata <= acc_nxt;
        end
        S_OUT: if (sm_tready) cnt <= cnt + W'(1);
        default: ;
      endcase
    end
  end
endmodule
